// File: rtl/rbcp_regfile.sv
// RBCP slave register file: RW byte registers, RO status words and a stretched command pulse.
// Define RBCP_REGFILE_SNAPSHOT_EN for coherent 16-bit status reads via a low-byte shadow.
module rbcp_regfile #(
  parameter logic [31:0]         BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned         N_RW        = 16,
  parameter int unsigned         N_RO        = 8,
  parameter logic [8*N_RW-1:0]   RESET_VAL   = {8*N_RW{1'b0}},
  parameter int unsigned         PULSE_WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RBCP_ACT,
  input  logic [31:0]         RBCP_ADDR,
  input  logic                RBCP_WE,
  input  logic                RBCP_RE,
  input  logic [7:0]          RBCP_WD,
  output logic                RBCP_ACK,
  output logic [7:0]          RBCP_RD,
  output logic [8*N_RW-1:0]   REG_OUT,
  output logic [N_RW-1:0]     WR_STROBE,
  input  logic [16*N_RO-1:0]  STATUS_IN,
  output logic [7:0]          CMD_PULSE
);

  localparam logic [31:0] RoBase  = 32'(N_RW);
  localparam logic [31:0] CmdOff  = 32'(N_RW + 2 * N_RO);
  localparam logic [7:0]  PwLast  = 8'(PULSE_WIDTH - 1);

  logic [8*N_RW-1:0] reg_q, reg_d;
  logic [N_RW-1:0]   wr_strobe_q, wr_strobe_d;
  logic              ack_q;
  logic [7:0]        rd_q, rd_d;
  logic [7:0]        cmd_q;
  logic [7:0]        cnt_q;

  logic [31:0] off, st_off, st_idx;
  logic        hit, do_wr, do_rd, is_rw, is_st, is_cmd, st_hi;
  logic [15:0] st_word;
  logic [7:0]  st_lo;

`ifdef RBCP_REGFILE_SNAPSHOT_EN
  logic [7:0] shadow_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_q <= 8'h00;
    end else if (do_rd && is_st && st_hi) begin
      shadow_q <= st_word[7:0];
    end
  end

  assign st_lo = shadow_q;
`else
  assign st_lo = st_word[7:0];
`endif

  always_comb begin
    off    = RBCP_ADDR - BASE_ADDR;
    st_off = off - RoBase;
    st_idx = {1'b0, st_off[31:1]};
    st_hi  = ~st_off[0];
    is_rw  = off < RoBase;
    is_st  = (off >= RoBase) && (off < CmdOff);
    is_cmd = off == CmdOff;
    // Strobes landing in the ACK cycle of the previous one are dropped.
    hit    = RBCP_ACT && (RBCP_WE || RBCP_RE) && (off <= CmdOff) && !ack_q;
    do_wr  = hit && RBCP_WE;
    do_rd  = hit && RBCP_RE && !RBCP_WE;
    st_word = 16'h0000;
    for (int k = 0; k < int'(N_RO); k++) begin
      if (st_idx == 32'(k)) st_word = STATUS_IN[16*k +: 16];
    end
  end

  always_comb begin
    reg_d       = reg_q;
    wr_strobe_d = '0;
    rd_d        = 8'h00;
    for (int i = 0; i < int'(N_RW); i++) begin
      if (off == 32'(i)) begin
        if (do_wr) begin
          reg_d[8*i +: 8] = RBCP_WD;
          wr_strobe_d[i]  = 1'b1;
        end
        if (do_rd) rd_d = reg_q[8*i +: 8];
      end
    end
    if (do_rd && is_st) rd_d = st_hi ? st_word[15:8] : st_lo;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      reg_q       <= RESET_VAL;
      wr_strobe_q <= '0;
      ack_q       <= 1'b0;
      rd_q        <= 8'h00;
    end else begin
      reg_q       <= reg_d;
      wr_strobe_q <= wr_strobe_d;
      ack_q       <= hit;
      rd_q        <= rd_d;
    end
  end

  // Shared countdown: any command write ORs new bits in and restarts the window for all.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cmd_q <= 8'h00;
      cnt_q <= 8'h00;
    end else if (do_wr && is_cmd) begin
      cmd_q <= cmd_q | RBCP_WD;
      cnt_q <= PwLast;
    end else if (cmd_q != 8'h00) begin
      if (cnt_q == 8'h00) cmd_q <= 8'h00;
      else                cnt_q <= cnt_q - 8'h01;
    end
  end

  // Reset masks outputs immediately so a pending ACK and its write never become visible.
  always_comb begin
    RBCP_ACK  = ack_q & ~RST;
    RBCP_RD   = RST ? 8'h00 : rd_q;
    REG_OUT   = RST ? RESET_VAL : reg_q;
    WR_STROBE = RST ? '0 : wr_strobe_q;
    CMD_PULSE = RST ? 8'h00 : cmd_q;
  end

endmodule

// File: tb/tb_rbcp_regfile.sv
// Self-checking bench for rbcp_regfile: directed scenarios plus randomized traffic vs a byte-map model.
// Expectations for status low-byte reads follow RBCP_REGFILE_SNAPSHOT_EN.
module tb_rbcp_regfile;

  localparam logic [31:0]  Base   = 32'h0000_0100;
  localparam int           NRw    = 16;
  localparam int           NRo    = 8;
  localparam logic [127:0] RstVal = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
  localparam int           Pw     = 4;
  localparam int           CmdO   = NRw + 2 * NRo;

  logic         CLK, RST, RBCP_ACT, RBCP_WE, RBCP_RE, RBCP_ACK;
  logic [31:0]  RBCP_ADDR;
  logic [7:0]   RBCP_WD, RBCP_RD, CMD_PULSE;
  logic [127:0] REG_OUT, STATUS_IN;
  logic [15:0]  WR_STROBE;

  int n_tests, n_fail;
  logic [7:0] exp_reg [NRw];
  logic [7:0] exp_shadow;

  rbcp_regfile #(
    .BASE_ADDR  (Base),
    .N_RW       (NRw),
    .N_RO       (NRo),
    .RESET_VAL  (RstVal),
    .PULSE_WIDTH(Pw)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RBCP_ACT (RBCP_ACT),
    .RBCP_ADDR(RBCP_ADDR),
    .RBCP_WE  (RBCP_WE),
    .RBCP_RE  (RBCP_RE),
    .RBCP_WD  (RBCP_WD),
    .RBCP_ACK (RBCP_ACK),
    .RBCP_RD  (RBCP_RD),
    .REG_OUT  (REG_OUT),
    .WR_STROBE(WR_STROBE),
    .STATUS_IN(STATUS_IN),
    .CMD_PULSE(CMD_PULSE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [127:0] model_regout();
    logic [127:0] v;
    for (int i = 0; i < NRw; i++) v[8*i +: 8] = exp_reg[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NRw; i++) exp_reg[i] = RstVal[8*i +: 8];
    exp_shadow = 8'h00;
  endtask

  // Present a strobe for one cycle; returns #1 after the edge that captured it (the ACK cycle).
  task automatic strobe(input logic we, input logic re, input logic [31:0] addr,
                        input logic [7:0] wd);
    RBCP_ACT = 1'b1; RBCP_WE = we; RBCP_RE = re; RBCP_ADDR = addr; RBCP_WD = wd;
    @(posedge CLK); #1;
    RBCP_ACT = 1'b0; RBCP_WE = 1'b0; RBCP_RE = 1'b0;
  endtask

  task automatic idle();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    n_tests += 5;
    if (REG_OUT !== model_regout()) begin
      n_fail++; $display("FAIL reset_reg_out got %h want %h", REG_OUT, model_regout());
    end
    if (WR_STROBE !== 16'h0) begin n_fail++; $display("FAIL reset_strobe got %h want 0", WR_STROBE); end
    if (CMD_PULSE !== 8'h0) begin n_fail++; $display("FAIL reset_cmd got %h want 0", CMD_PULSE); end
    if (RBCP_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", RBCP_ACK); end
    if (RBCP_RD !== 8'h0) begin n_fail++; $display("FAIL reset_rd got %h want 0", RBCP_RD); end
  endtask

  task automatic test_write_rw();
    strobe(1'b1, 1'b0, Base + 32'd3, 8'hA5);
    exp_reg[3] = 8'hA5;
    n_tests += 4;
    if (RBCP_ACK !== 1'b1) begin n_fail++; $display("FAIL wr_ack got %b want 1", RBCP_ACK); end
    if (REG_OUT[31:24] !== 8'hA5) begin
      n_fail++; $display("FAIL wr_reg3 got %h want a5", REG_OUT[31:24]);
    end
    if (WR_STROBE !== 16'h0008) begin
      n_fail++; $display("FAIL wr_strobe got %h want 0008", WR_STROBE);
    end
    if (RBCP_RD !== 8'h00) begin n_fail++; $display("FAIL wr_rd got %h want 0", RBCP_RD); end
    idle();
    n_tests += 1;
    if ({RBCP_ACK, WR_STROBE} !== 17'h0) begin
      n_fail++; $display("FAIL wr_after got ack %b strb %h want 0", RBCP_ACK, WR_STROBE);
    end
  endtask

  task automatic test_rst_priority();
    RST = 1'b1;
    RBCP_ACT = 1'b1; RBCP_WE = 1'b1; RBCP_RE = 1'b0; RBCP_ADDR = Base + 32'd2; RBCP_WD = 8'h99;
    @(posedge CLK); #1;
    RBCP_ACT = 1'b0; RBCP_WE = 1'b0; RST = 1'b0;
    model_reset();
    n_tests += 2;
    if (RBCP_ACK !== 1'b0) begin n_fail++; $display("FAIL rstprio_ack got %b want 0", RBCP_ACK); end
    if (REG_OUT !== model_regout()) begin
      n_fail++; $display("FAIL rstprio_reg got %h want %h", REG_OUT, model_regout());
    end
  endtask

  task automatic test_both_strobes();
    strobe(1'b1, 1'b1, Base + 32'd1, 8'h3C);
    exp_reg[1] = 8'h3C;
    n_tests += 3;
    if (RBCP_ACK !== 1'b1) begin n_fail++; $display("FAIL both_ack got %b want 1", RBCP_ACK); end
    if (REG_OUT[15:8] !== 8'h3C) begin
      n_fail++; $display("FAIL both_reg1 got %h want 3c", REG_OUT[15:8]);
    end
    if (RBCP_RD !== 8'h00) begin n_fail++; $display("FAIL both_rd got %h want 0", RBCP_RD); end
    idle();
    n_tests += 1;
    if (RBCP_ACK !== 1'b0) begin n_fail++; $display("FAIL both_single_ack got %b want 0", RBCP_ACK); end
  endtask

  task automatic test_pending_ignored();
    RBCP_ACT = 1'b1; RBCP_WE = 1'b1; RBCP_RE = 1'b0; RBCP_ADDR = Base + 32'd4; RBCP_WD = 8'h11;
    @(posedge CLK); #1;
    RBCP_WD = 8'h22;
    exp_reg[4] = 8'h11;
    n_tests += 1;
    if (RBCP_ACK !== 1'b1) begin n_fail++; $display("FAIL pend_ack got %b want 1", RBCP_ACK); end
    @(posedge CLK); #1;
    RBCP_ACT = 1'b0; RBCP_WE = 1'b0;
    n_tests += 2;
    if (RBCP_ACK !== 1'b0) begin n_fail++; $display("FAIL pend_second_ack got %b want 0", RBCP_ACK); end
    if (REG_OUT[39:32] !== 8'h11) begin
      n_fail++; $display("FAIL pend_reg4 got %h want 11", REG_OUT[39:32]);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [2];
    addrs[0] = Base + 32'(CmdO + 1);
    addrs[1] = Base - 32'd1;
    for (int j = 0; j < 2; j++) begin
      strobe(1'b0, 1'b1, addrs[j], 8'h00);
      n_tests += 1;
      if ({RBCP_ACK, RBCP_RD} !== 9'h0) begin
        n_fail++; $display("FAIL unmapped_%0d got ack %b rd %h want 0 0", j, RBCP_ACK, RBCP_RD);
      end
      strobe(1'b1, 1'b0, addrs[j], 8'hEE);
      n_tests += 1;
      if (RBCP_ACK !== 1'b0 || REG_OUT !== model_regout() || CMD_PULSE !== 8'h0) begin
        n_fail++; $display("FAIL unmapped_wr_%0d got ack %b reg %h want 0 %h",
                           j, RBCP_ACK, REG_OUT, model_regout());
      end
      idle();
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] want_lo;
    STATUS_IN[15:0] = 16'h12FF;
    strobe(1'b0, 1'b1, Base + 32'(NRw), 8'h00);
    exp_shadow = 8'hFF;
    n_tests += 1;
    if (RBCP_RD !== 8'h12) begin n_fail++; $display("FAIL snap_hi got %h want 12", RBCP_RD); end
    STATUS_IN[15:0] = 16'h1300;
    idle();
`ifdef RBCP_REGFILE_SNAPSHOT_EN
    want_lo = 8'hFF;
`else
    want_lo = 8'h00;
`endif
    strobe(1'b0, 1'b1, Base + 32'(NRw + 1), 8'h00);
    n_tests += 1;
    if (RBCP_RD !== want_lo) begin n_fail++; $display("FAIL snap_lo got %h want %h", RBCP_RD, want_lo); end
    idle();
  endtask

  task automatic test_cmd_pulse();
    int c0, c1, c2;
    logic [7:0] at3;
    c0 = 0; c1 = 0; c2 = 0; at3 = 8'h00;
    RBCP_ACT = 1'b1; RBCP_WE = 1'b1; RBCP_RE = 1'b0; RBCP_ADDR = Base + 32'(CmdO); RBCP_WD = 8'h05;
    for (int i = 1; i <= 12; i++) begin
      @(posedge CLK); #1;
      RBCP_ACT = 1'b0; RBCP_WE = 1'b0;
      if (i == 2) begin RBCP_ACT = 1'b1; RBCP_WE = 1'b1; RBCP_WD = 8'h02; end
      c0 += int'(CMD_PULSE[0]);
      c1 += int'(CMD_PULSE[1]);
      c2 += int'(CMD_PULSE[2]);
      if (i == 3) at3 = CMD_PULSE;
    end
    n_tests += 5;
    if (c0 != 6) begin n_fail++; $display("FAIL cmd_bit0 got %0d cycles want 6", c0); end
    if (c1 != 4) begin n_fail++; $display("FAIL cmd_bit1 got %0d cycles want 4", c1); end
    if (c2 != 6) begin n_fail++; $display("FAIL cmd_bit2 got %0d cycles want 6", c2); end
    if (at3 !== 8'h07) begin n_fail++; $display("FAIL cmd_overlap got %h want 07", at3); end
    if (CMD_PULSE !== 8'h00) begin n_fail++; $display("FAIL cmd_clear got %h want 0", CMD_PULSE); end
    strobe(1'b0, 1'b1, Base + 32'(CmdO), 8'h00);
    n_tests += 1;
    if (RBCP_ACK !== 1'b1 || RBCP_RD !== 8'h00) begin
      n_fail++; $display("FAIL cmd_read got ack %b rd %h want 1 00", RBCP_ACK, RBCP_RD);
    end
    idle();
  endtask

  task automatic test_rst_cancel();
    RBCP_ACT = 1'b1; RBCP_WE = 1'b1; RBCP_RE = 1'b0; RBCP_ADDR = Base; RBCP_WD = ~RstVal[7:0];
    @(posedge CLK); #1;
    RBCP_ACT = 1'b0; RBCP_WE = 1'b0;
    RST = 1'b1;
    #1;
    n_tests += 1;
    if (RBCP_ACK !== 1'b0) begin n_fail++; $display("FAIL rstcancel_ack got %b want 0", RBCP_ACK); end
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    n_tests += 2;
    if (REG_OUT[7:0] !== RstVal[7:0]) begin
      n_fail++; $display("FAIL rstcancel_reg0 got %h want %h", REG_OUT[7:0], RstVal[7:0]);
    end
    if (RBCP_ACK !== 1'b0) begin n_fail++; $display("FAIL rstcancel_ack2 got %b want 0", RBCP_ACK); end
  endtask

  task automatic test_random();
    int kind, off, k;
    logic we, re, mapped;
    logic [7:0] wd, exp_rd;
    logic [15:0] word, exp_strb;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 5) == 0) STATUS_IN = {$urandom, $urandom, $urandom, $urandom};
      kind = int'($urandom_range(0, 5));
      wd   = 8'($urandom);
      case (kind)
        0, 1:    off = int'($urandom_range(0, NRw - 1));
        2, 3:    off = NRw + int'($urandom_range(0, 2 * NRo - 1));
        4:       off = CmdO;
        default: off = CmdO + 1 + int'($urandom_range(0, 1000));
      endcase
      we = (kind == 0 || kind == 3 || (kind == 5 && $urandom_range(0, 1) == 1));
      re = !we;
      mapped = off <= CmdO;
      exp_rd = 8'h00;
      exp_strb = 16'h0;
      if (mapped && we && off < NRw) begin
        exp_reg[off] = wd;
        exp_strb[off] = 1'b1;
      end else if (mapped && re && off < NRw) begin
        exp_rd = exp_reg[off];
      end else if (mapped && re && off < CmdO) begin
        k = (off - NRw) / 2;
        word = STATUS_IN[16*k +: 16];
        if ((off - NRw) % 2 == 0) begin
          exp_rd = word[15:8];
          exp_shadow = word[7:0];
        end else begin
`ifdef RBCP_REGFILE_SNAPSHOT_EN
          exp_rd = exp_shadow;
`else
          exp_rd = word[7:0];
`endif
        end
      end
      strobe(we, re, Base + 32'(off), wd);
      n_tests += 1;
      if (RBCP_ACK !== mapped || RBCP_RD !== exp_rd || WR_STROBE !== exp_strb ||
          REG_OUT !== model_regout()) begin
        n_fail++;
        $display("FAIL rand_%0d off %0d we %b got ack %b rd %h strb %h reg %h want %b %h %h %h",
                 n, off, we, RBCP_ACK, RBCP_RD, WR_STROBE, REG_OUT,
                 mapped, exp_rd, exp_strb, model_regout());
      end
      idle();
      n_tests += 1;
      if ({RBCP_ACK, RBCP_RD, WR_STROBE} !== 25'h0) begin
        n_fail++; $display("FAIL rand_idle_%0d got ack %b rd %h strb %h want 0",
                           n, RBCP_ACK, RBCP_RD, WR_STROBE);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    RST = 1'b1; RBCP_ACT = 1'b0; RBCP_WE = 1'b0; RBCP_RE = 1'b0;
    RBCP_ADDR = 32'h0; RBCP_WD = 8'h0; STATUS_IN = '0;
    test_reset();
    test_write_rw();
    test_rst_priority();
    test_both_strobes();
    test_pending_ignored();
    test_unmapped();
    test_snapshot();
    test_cmd_pulse();
    test_rst_cancel();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
